// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: ALU operand forward selects and
// the dmem wait FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/RAW/dmem stalls, branch
// flushes, a dmem wait FSM with sticky timeout, and stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              result_src_e0,
    input  logic              pcsrc_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mem_wait,
    output logic              mem_err
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

    function automatic fwd_sel_e fwd_src(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rdm,
                                         input logic              wm,
                                         input logic [REG_AW-1:0] rdw,
                                         input logic              ww);
        if (wm && (rdm != '0) && (rdm == rs)) return FWD_M;
        if (ww && (rdw != '0) && (rdw == rs)) return FWD_W;
        return FWD_RF;
    endfunction

    // Write-through register file: only E and M producers can cause a RAW hazard.
    function automatic logic raw_hit(input logic [REG_AW-1:0] rs);
        return (rs != '0) && ((reg_write_e && (rd_e == rs)) ||
                              (reg_write_m && (rd_m == rs)));
    endfunction

    logic lw_stall;
    logic raw_stall;
    logic mem_stall;

    always_comb begin
        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        if (FWD_EN != 0) begin
            forward_ae = fwd_src(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
            forward_be = fwd_src(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
        end

        lw_stall  = result_src_e0 && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
        raw_stall = (FWD_EN == 0) && (raw_hit(rs1_d) || raw_hit(rs2_d));
        mem_stall = mem_req_m && !mem_ready;

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall || raw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    mem_state_e     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_MAX) begin
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_wait = (state_q == WAIT);
    assign mem_err  = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (stall_f),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (flush_d),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a stall-only instance
// (CNT_W=2, MEM_TIMEOUT=4) share stimulus and are checked against a rule model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reg_write_e, result_src_e0, pcsrc_e, reg_write_m, reg_write_w;
    logic       mem_req_m, mem_ready, cnt_clr;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;

    logic        sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, wait_a, err_a;
    logic [1:0]  fa_a, fb_a;
    logic [15:0] scnt_a, fcnt_a;
    logic        sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, wait_b, err_b;
    logic [1:0]  fa_b, fb_b;
    logic [1:0]  scnt_b, fcnt_b;

    hazard_ctrl u_a (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e),
        .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .result_src_e0(result_src_e0), .pcsrc_e(pcsrc_e), .rd_m(rd_m),
        .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .stall_f(sf_a), .stall_d(sd_a), .stall_e(se_a), .stall_m(sm_a),
        .flush_d(fd_a), .flush_e(fe_a), .flush_w(fw_a), .forward_ae(fa_a),
        .forward_be(fb_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a),
        .mem_wait(wait_a), .mem_err(err_a)
    );

    hazard_ctrl #(.FWD_EN(0), .CNT_W(2), .MEM_TIMEOUT(4)) u_b (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e),
        .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .result_src_e0(result_src_e0), .pcsrc_e(pcsrc_e), .rd_m(rd_m),
        .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .stall_f(sf_b), .stall_d(sd_b), .stall_e(se_b), .stall_m(sm_b),
        .flush_d(fd_b), .flush_e(fe_b), .flush_w(fw_b), .forward_ae(fa_b),
        .forward_be(fb_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b),
        .mem_wait(wait_b), .mem_err(err_b)
    );

    logic [10:0] comb_o [2];
    logic [15:0] scnt_o [2];
    logic [15:0] fcnt_o [2];
    logic        wait_o [2];
    logic        err_o  [2];
    assign comb_o[0] = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, fa_a, fb_a};
    assign comb_o[1] = {sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, fa_b, fb_b};
    assign scnt_o[0] = scnt_a;
    assign scnt_o[1] = {14'd0, scnt_b};
    assign fcnt_o[0] = fcnt_a;
    assign fcnt_o[1] = {14'd0, fcnt_b};
    assign wait_o[0] = wait_a;
    assign wait_o[1] = wait_b;
    assign err_o[0]  = err_a;
    assign err_o[1]  = err_b;

    // Reference model: per-instance parameters and abstract state.
    int fwd_en  [2] = '{1, 0};
    int cnt_max [2] = '{65535, 3};
    int tmo     [2] = '{64, 4};
    bit waiting [2];
    int wcnt    [2];
    bit err_m   [2];
    int scnt_m  [2];
    int fcnt_m  [2];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_of(int d, logic [4:0] rs);
        if (fwd_en[d] == 0) return 2'b00;
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit dep(logic [4:0] rs);
        return rs != 0 && ((reg_write_e && rd_e == rs) || (reg_write_m && rd_m == rs));
    endfunction

    // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,fwd_a,fwd_b}
    function automatic logic [10:0] exp_comb(int d);
        bit ms, lw, raw;
        logic [6:0] ctl;
        ms  = mem_req_m && !mem_ready;
        lw  = result_src_e0 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        raw = fwd_en[d] == 0 && (dep(rs1_d) || dep(rs2_d));
        if (ms)             ctl = 7'b1111001;
        else if (pcsrc_e)   ctl = 7'b0000110;
        else if (lw || raw) ctl = 7'b1100010;
        else                ctl = 7'b0000000;
        return {ctl, fwd_of(d, rs1_e), fwd_of(d, rs2_e)};
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [10:0] e;
            e = exp_comb(d);
            if (reset) begin
                waiting[d] = 0; wcnt[d] = 0; err_m[d] = 0; scnt_m[d] = 0; fcnt_m[d] = 0;
            end else begin
                if (cnt_clr) begin
                    scnt_m[d] = 0; fcnt_m[d] = 0;
                end else begin
                    if (e[10] && scnt_m[d] < cnt_max[d]) scnt_m[d]++;
                    if (e[6]  && fcnt_m[d] < cnt_max[d]) fcnt_m[d]++;
                end
                if (!waiting[d]) begin
                    if (mem_req_m && !mem_ready) begin
                        waiting[d] = 1; wcnt[d] = 0;
                    end
                end else begin
                    if (wcnt[d] >= tmo[d]) err_m[d] = 1;
                    else wcnt[d]++;
                    if (mem_ready) waiting[d] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d == 0 ? "comb_a" : "comb_b", 32'(comb_o[d]), 32'(exp_comb(d)));
            chk(d == 0 ? "stall_cnt_a" : "stall_cnt_b", 32'(scnt_o[d]), 32'(scnt_m[d]));
            chk(d == 0 ? "flush_cnt_a" : "flush_cnt_b", 32'(fcnt_o[d]), 32'(fcnt_m[d]));
            chk(d == 0 ? "mem_wait_a" : "mem_wait_b", 32'(wait_o[d]), 32'(waiting[d]));
            chk(d == 0 ? "mem_err_a" : "mem_err_b", 32'(err_o[d]), 32'(err_m[d]));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 0; reg_write_e = 0; result_src_e0 = 0; pcsrc_e = 0; reg_write_m = 0;
        reg_write_w = 0; mem_req_m = 0; mem_ready = 1; cnt_clr = 0;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    endtask

    initial begin
        quiet();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            waiting[d] = 0; wcnt[d] = 0; err_m[d] = 0; scnt_m[d] = 0; fcnt_m[d] = 0;
        end
        // Reset state, with combinational outputs still following inputs.
        rs1_e = 5; rd_m = 5; reg_write_m = 1;
        #1 chk("fwd_in_reset", 32'(fa_a), 32'h2);
        cycle();
        quiet();

        // Forwarding priority M > W > register file.
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
        #1 chk("fwd_m", 32'(fa_a), 32'h2);
        chk("fwd_off", 32'(fa_b), 32'h0);
        cycle();
        reg_write_m = 0;
        #1 chk("fwd_w", 32'(fa_a), 32'h1);
        cycle();
        rs1_e = 0;
        #1 chk("fwd_x0", 32'(fa_a), 32'h0);
        cycle();
        quiet();

        // Load-use stall, then the same with a taken branch.
        result_src_e0 = 1; rd_e = 7; rs2_d = 7;
        #1 chk("lw_stall", 32'({sf_a, sd_a, fe_a}), 32'h7);
        cycle();
        quiet();
        #1 chk("lw_stall_cnt", 32'(scnt_a), 32'h1);
        result_src_e0 = 1; rd_e = 7; rs2_d = 7; pcsrc_e = 1;
        #1 chk("br_over_lw", 32'({sf_a, fd_a, fe_a}), 32'h3);
        cycle();
        quiet();
        #1 chk("br_flush_cnt", 32'(fcnt_a), 32'h1);
        cnt_clr = 1;
        cycle();
        quiet();

        // dmem stall beats a taken branch.
        mem_req_m = 1; mem_ready = 0; pcsrc_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ms_ctl", 32'({sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a}), 32'h79);
            if (i > 0) chk("ms_wait", 32'(wait_a), 32'h1);
            cycle();
        end
        mem_ready = 1; pcsrc_e = 0;
        #1 chk("ms_cnt", 32'(scnt_a), 32'h3);
        cycle();
        chk("ms_idle", 32'(wait_a), 32'h0);
        quiet();

        // Timeout: instance b expires after 5 WAIT cycles, instance a after 65.
        mem_req_m = 1; mem_ready = 0;
        repeat (5) cycle();
        chk("tmo_before", 32'(err_b), 32'h0);
        cycle();
        chk("tmo_set", 32'(err_b), 32'h1);
        repeat (62) cycle();
        mem_ready = 1;
        cycle();
        chk("tmo_sticky", 32'(err_b), 32'h1);
        chk("tmo_default", 32'(err_a), 32'h1);
        quiet();
        reset = 1;
        cycle();
        chk("tmo_reset", 32'(err_b), 32'h0);
        quiet();

        // Stall-only instance: RAW stall without forwarding, 2-bit saturation.
        rd_m = 3; reg_write_m = 1; rs1_d = 3; rs1_e = 3;
        #1 chk("raw_ctl", 32'({sf_b, sd_b, fe_b, fa_b}), 32'h1C);
        chk("raw_fwd_a", 32'({sf_a, fa_a}), 32'h2);
        repeat (5) cycle();
        chk("sat_cnt", 32'(scnt_b), 32'h3);
        quiet();

        // Randomized traffic, with occasional reset and clear.
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 59) == 0);
            cnt_clr       = ($urandom_range(0, 24) == 0);
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_write_e   = 1'($urandom);
            reg_write_m   = 1'($urandom);
            reg_write_w   = 1'($urandom);
            result_src_e0 = 1'($urandom);
            pcsrc_e       = ($urandom_range(0, 3) == 0);
            mem_req_m     = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 9) < 6);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 selects forwarding; 0 resolves every RAW hazard by stalling.
REQ-003 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 64: dmem wait cycles before mem_err is raised.
REQ-005 SHALL have ports, one per line:
 clk  in  1  single clock; all state changes on rising edge.
 reset  in  1  synchronous, active-high.
 rs1_d, rs2_d  in  REG_AW  source registers of the Decode instruction.
 rs1_e, rs2_e, rd_e  in  REG_AW  Execute-stage register fields.
 reg_write_e  in  1  Execute instruction writes rd.
 result_src_e0  in  1  Execute instruction is a load.
 pcsrc_e  in  1  branch taken or jump in Execute.
 rd_m, reg_write_m  in  REG_AW, 1  Memory-stage destination and write enable.
 rd_w, reg_write_w  in  REG_AW, 1  Writeback-stage destination and write enable.
 mem_req_m  in  1  Memory-stage instruction accesses dmem.
 mem_ready  in  1  dmem completes the access this cycle.
 cnt_clr  in  1  clears both counters.
 stall_f, stall_d, stall_e, stall_m  out  1  hold the F/D/E/M pipeline registers.
 flush_d, flush_e, flush_w  out  1  insert a bubble into D/E/W.
 forward_ae, forward_be  out  2  ALU operand A/B source select.
 stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
 mem_wait  out  1  FSM is in WAIT.
 mem_err  out  1  sticky dmem timeout flag.

Function
REQ-006 SHALL drive all stall, flush and forward outputs combinationally in the same cycle as their inputs; counters, FSM and mem_err SHALL be registered with 1-cycle latency.
REQ-007 SHALL set forward_ae to 10 when FWD_EN=1, reg_write_m=1, rd_m!=0 and rd_m==rs1_e; otherwise to 01 when reg_write_w=1, rd_w!=0 and rd_w==rs1_e; otherwise to 00. forward_be SHALL be computed identically using rs2_e.
REQ-008 SHALL hold forward_ae and forward_be at 00 when FWD_EN=0.
REQ-009 SHALL assert lw_stall when result_src_e0=1, rd_e!=0 and rd_e equals rs1_d or rs2_d.
REQ-010 SHALL, when FWD_EN=0, also assert raw_stall when rs1_d or rs2_d is nonzero and matches rd_e with reg_write_e=1 or rd_m with reg_write_m=1; the register file is write-through, so W is excluded.
REQ-011 SHALL assert mem_stall = mem_req_m & ~mem_ready.
REQ-012 SHALL apply this priority: mem_stall > pcsrc_e > (lw_stall | raw_stall).
REQ-013 On mem_stall: stall_f=stall_d=stall_e=stall_m=1, flush_w=1, and flush_d=flush_e=0 even if pcsrc_e=1.
REQ-014 On pcsrc_e without mem_stall: flush_d=flush_e=1 and all stalls 0; any load-use or RAW stall is suppressed.
REQ-015 On lw_stall or raw_stall alone: stall_f=stall_d=1, flush_e=1, all other outputs 0.
REQ-016 SHALL implement an FSM with states IDLE and WAIT: IDLE->WAIT on mem_stall; WAIT->IDLE on mem_ready; mem_wait=1 in WAIT.
REQ-017 SHALL run wait_cnt in WAIT, cleared on entry, saturating at MEM_TIMEOUT; when wait_cnt reaches MEM_TIMEOUT, mem_err SHALL be set and held until reset.
REQ-018 SHALL increment stall_cnt on every cycle with stall_f=1, and flush_cnt on every cycle with flush_d=1; both SHALL saturate at all-ones.
REQ-019 cnt_clr SHALL zero both counters on the next edge, taking priority over a simultaneous increment.

Reset
REQ-020 On reset: FSM=IDLE, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_err=0, mem_wait=0.
REQ-021 Reset SHALL take priority over every other event, including mid-WAIT; combinational outputs SHALL continue to follow their inputs during reset.

Structure
REQ-022 A shared package hazard_pkg SHALL hold the forward encodings (FWD_RF=00, FWD_W=01, FWD_M=10) and the FSM state encoding (IDLE, WAIT).
REQ-023 SHALL instantiate sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q) for stall_cnt and flush_cnt.

Verification
REQ-024 FWD_EN=1, rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_ae=10; clear reg_write_m -> forward_ae=01; rs1_e=0 -> 00.
REQ-025 result_src_e0=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle, stall_cnt 0->1.
REQ-026 Same as REQ-025 plus pcsrc_e=1 -> flush_d=flush_e=1, stall_f=0, flush_cnt 0->1.
REQ-027 mem_req_m=1, mem_ready=0 for 3 cycles with pcsrc_e=1 -> all stalls=1, flush_w=1, flush_d=0, mem_wait=1 from cycle 2, stall_cnt=3; mem_ready=1 -> IDLE.
REQ-028 MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 5 WAIT cycles; it stays 1 after mem_ready=1, and reset clears it.
REQ-029 FWD_EN=0, rd_m=3, reg_write_m=1, rs1_d=3 -> stall_f=stall_d=flush_e=1, forward_ae=00; CNT_W=2 with 5 stalls -> stall_cnt=3.
